// File: rtl/seq_ram_pkg.sv
// Shared constants and enums for the sequence-RAM arbiter.
package seq_ram_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 20;

    typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_e;
    typedef enum logic {OWN_WR = 1'b0, OWN_RD = 1'b1} owner_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0] = writer, req[1] = reader.
// On a tie the requester that was not granted last wins.
module rr_arb2
    import seq_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    owner_e last;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (last == OWN_RD) ? 2'b01 : 2'b10;
    end

    // Reset to OWN_RD so the writer wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last <= OWN_RD;
        else if (update && (gnt != 2'b00))
            last <= gnt[1] ? OWN_RD : OWN_WR;
    end
endmodule

// File: rtl/seq_ram_arbiter.sv
// Single-port sequence RAM owner: arbitrates store writes and playback reads.
// Define SEQ_ARB_STATS_EN to add saturating write/read/conflict counters.
module seq_ram_arbiter
    import seq_ram_pkg::*;
#(
    parameter int ADDR_W = seq_ram_pkg::ADDR_W,
    parameter int DATA_W = seq_ram_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic              RAM_W,
    output logic [DATA_W-1:0] RAM_din,
    input  logic [DATA_W-1:0] RAM_dout
`ifdef SEQ_ARB_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       conflict_cnt
`endif
);
    state_e     state, state_nxt;
    logic [1:0] gnt;
    logic [1:0] cnt;
    logic       rd_done;

    // Arbitration result is only acted on while IDLE.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({rd_req, wr_req}),
        .update (state == IDLE),
        .gnt    (gnt)
    );

    assign rd_done = (state == READ_WAIT) && (cnt == 2'd0);
    assign wr_gnt  = (state == WRITE);
    assign rd_gnt  = (state == READ);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt[0])      state_nxt = WRITE;
                else if (gnt[1]) state_nxt = READ;
            end
            WRITE:     state_nxt = IDLE;
            READ:      state_nxt = READ_WAIT;
            READ_WAIT: if (cnt == 2'd0) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            RAM_addr <= '0;
            RAM_din  <= '0;
            RAM_W    <= 1'b0;
            cnt      <= 2'd0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nxt;
            RAM_W <= (state_nxt == WRITE);
            if (state == IDLE && gnt[0]) begin
                RAM_addr <= wr_addr;
                RAM_din  <= wr_data;
            end else if (state == IDLE && gnt[1]) begin
                RAM_addr <= rd_addr;
            end
            // Counts remaining RAM latency cycles after the address is presented.
            if (state == READ)
                cnt <= 2'(RD_LAT - 1);
            else if (state == READ_WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            rd_valid <= rd_done;
            if (rd_done)
                rd_data <= RAM_dout;
        end
    end

`ifdef SEQ_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (state == WRITE && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
            if (state == READ && rd_cnt != 16'hFFFF)
                rd_cnt <= rd_cnt + 16'd1;
            if (state == IDLE && wr_req && rd_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_seq_ram_arbiter.sv
// Randomized self-checking bench for seq_ram_arbiter with a transaction-level model.
module tb_seq_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 20;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt, rd_gnt, rd_valid, RAM_W;
    logic [DW-1:0] rd_data, RAM_din, RAM_dout;
    logic [AW-1:0] RAM_addr;
`ifdef SEQ_ARB_STATS_EN
    logic [15:0]   wr_cnt, rd_cnt, conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    seq_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .RAM_addr(RAM_addr), .RAM_W(RAM_W), .RAM_din(RAM_din), .RAM_dout(RAM_dout)
`ifdef SEQ_ARB_STATS_EN
        , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM macro with RD_LAT cycles of read latency.
    logic [DW-1:0] ram [32];
    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (RAM_W) ram[RAM_addr] <= RAM_din;
        rpipe[0] <= ram[RAM_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign RAM_dout = rpipe[RD_LAT-1];

    // Transaction-level reference: memory contents and who was granted last (0 wr, 1 rd).
    logic [DW-1:0] mem_m [32];
    bit            written [32];
    int            wq[$];
    int            last_m = 1;

    task automatic mark(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_m[a] = d;
        if (!written[a]) begin written[a] = 1'b1; wq.push_back(int'(a)); end
    endtask

    // Predicts service order, grant/valid cycle offsets and read data for one request pair.
    task automatic model_xfer(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit r, input logic [AW-1:0] ra,
                              output int ef, output int ewg, output int erg, output int erv,
                              output logic [DW-1:0] ed);
        ef = -1; ewg = 0; erg = 0; erv = 0; ed = '0;
        if (w && r) ef = (last_m == 1) ? 0 : 1;
        else if (w) ef = 0;
        else if (r) ef = 1;
        if (ef == 0) begin
            mark(wa, wd); ewg = 1;
            if (r) begin erg = 3; erv = RD_LAT + 4; ed = mem_m[ra]; end
        end else if (ef == 1) begin
            erg = 1; erv = RD_LAT + 2; ed = mem_m[ra];
            if (w) begin ewg = RD_LAT + 3; mark(wa, wd); end
        end
        if (ef >= 0) last_m = (w && r) ? 1 - ef : ef;
    endtask

    // Drives one write and/or read request from IDLE and records what the DUT did.
    task automatic xfer(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit r, input logic [AW-1:0] ra,
                        output int first, output int wg, output int rg, output int rv,
                        output int nvld, output int nramw,
                        output logic [AW-1:0] ga, output logic [DW-1:0] gd,
                        output logic [DW-1:0] rdat);
        bit wpend, rpend;
        first = -1; wg = 0; rg = 0; rv = 0; nvld = 0; nramw = 0;
        ga = '0; gd = '0; rdat = '0;
        wpend = w; rpend = r;
        wr_addr = wa; wr_data = wd; rd_addr = ra; wr_req = w; rd_req = r;
        for (int c = 1; c <= 60 && (wpend || rpend); c++) begin
            @(negedge clk);
            if (RAM_W) nramw++;
            if (wr_gnt) begin
                if (first < 0) first = 0;
                wg = c; ga = RAM_addr; gd = RAM_din; wr_req = 1'b0; wpend = 1'b0;
            end
            if (rd_gnt) begin
                if (first < 0) first = 1;
                rg = c; rd_req = 1'b0;
            end
            if (rd_valid) begin nvld++; rv = c; rdat = rd_data; rpend = 1'b0; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        if (RAM_W) nramw++;
        if (rd_valid) nvld++;
    endtask

    task automatic do_reset();
        wr_req = 1'b0; rd_req = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; last_m = 1;
    endtask

    // Runs one request pair through DUT and model and compares everything observable.
    task automatic run_pair(input string tag, input bit w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra);
        int f, wg, rg, rv, nv, nw, ef, ewg, erg, erv;
        logic [AW-1:0] ga; logic [DW-1:0] gd, rdat, ed;
        xfer(w, wa, wd, r, ra, f, wg, rg, rv, nv, nw, ga, gd, rdat);
        model_xfer(w, wa, wd, r, ra, ef, ewg, erg, erv, ed);
        checks++;
        if (f !== ef || wg !== ewg || rg !== erg || rv !== erv) begin
            errors++;
            $display("FAIL %s order/timing: first=%0d wg=%0d rg=%0d rv=%0d, want first=%0d wg=%0d rg=%0d rv=%0d",
                     tag, f, wg, rg, rv, ef, ewg, erg, erv);
        end
        checks++;
        if (nv !== int'(r) || nw !== int'(w)) begin
            errors++;
            $display("FAIL %s pulses: rd_valid=%0d RAM_W=%0d, want %0d %0d", tag, nv, nw, r, w);
        end
        if (w) begin
            checks++;
            if (ga !== wa || gd !== wd) begin
                errors++;
                $display("FAIL %s ram_wr: addr=%0d din=%h, want %0d %h", tag, ga, gd, wa, wd);
            end
        end
        if (r) begin
            checks++;
            if (rdat !== ed) begin
                errors++;
                $display("FAIL %s rd_data: got %h want %h (addr %0d)", tag, rdat, ed, ra);
            end
        end
    endtask

    task automatic test_reset();
        wr_req = 1'b1; wr_addr = 5'd1; wr_data = 20'hABCDE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_gnt, rd_gnt, rd_valid, RAM_W, RAM_addr, RAM_din, rd_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: wr_gnt=%b rd_gnt=%b rd_valid=%b RAM_W=%b addr=%0d din=%h rd_data=%h, want all 0",
                         wr_gnt, rd_gnt, rd_valid, RAM_W, RAM_addr, RAM_din, rd_data);
            end
        end
        rst = 1'b1; last_m = 1;
        @(negedge clk);
        checks++;
        if (wr_gnt !== 1'b1 || RAM_W !== 1'b1 || RAM_addr !== 5'd1 || RAM_din !== 20'hABCDE) begin
            errors++;
            $display("FAIL reset_first_write: wr_gnt=%b RAM_W=%b addr=%0d din=%h, want 1 1 1 abcde",
                     wr_gnt, RAM_W, RAM_addr, RAM_din);
        end
        wr_req = 1'b0;
        mark(5'd1, 20'hABCDE); last_m = 0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        run_pair("wr_58ea3", 1'b1, 5'd3, 20'h58EA3, 1'b0, 5'd0);
        run_pair("rd_addr3", 1'b0, 5'd0, 20'h0, 1'b1, 5'd3);
        checks++;
        if (mem_m[3] !== 20'h58EA3) begin
            errors++;
            $display("FAIL model_addr3: got %h want 58ea3", mem_m[3]);
        end
    endtask

    // Writer wins ties while the reader was served last, and vice versa.
    task automatic test_simultaneous();
        bit wp [6] = '{1, 1, 1, 1, 0, 1};
        bit rp [6] = '{1, 1, 0, 1, 1, 1};
        do_reset();
        run_pair("tie0", 1'b1, 5'd7, 20'h74DBA, 1'b1, 5'd3);
        for (int i = 1; i < 6; i++) begin
            logic [AW-1:0] wa;
            wa = (i % 2 == 1) ? 5'd7 : AW'($urandom);
            run_pair($sformatf("tie%0d", i), wp[i], wa, DW'($urandom), rp[i], 5'd7);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        wr_req = 1'b1; wr_addr = 5'd31; wr_data = 20'h13579;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = wr_gnt;
        end
        checks++;
        if (!seen || RAM_W !== 1'b1 || RAM_addr !== 5'd31 || RAM_din !== 20'h13579) begin
            errors++;
            $display("FAIL b2b_first: seen=%b RAM_W=%b addr=%0d din=%h, want 1 1 31 13579",
                     seen, RAM_W, RAM_addr, RAM_din);
        end
        wr_addr = 5'd0; wr_data = 20'h2468A;
        @(negedge clk);
        checks++;
        if (RAM_W !== 1'b0 || wr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: RAM_W=%b wr_gnt=%b, want 0 0", RAM_W, wr_gnt);
        end
        @(negedge clk);
        checks++;
        if (wr_gnt !== 1'b1 || RAM_W !== 1'b1 || RAM_addr !== 5'd0 || RAM_din !== 20'h2468A) begin
            errors++;
            $display("FAIL b2b_second: wr_gnt=%b RAM_W=%b addr=%0d din=%h, want 1 1 0 2468a",
                     wr_gnt, RAM_W, RAM_addr, RAM_din);
        end
        wr_req = 1'b0;
        mark(5'd31, 20'h13579); mark(5'd0, 20'h2468A); last_m = 0;
        @(negedge clk);
        run_pair("b2b_rd31", 1'b0, 5'd0, 20'h0, 1'b1, 5'd31);
        run_pair("b2b_rd0", 1'b0, 5'd0, 20'h0, 1'b1, 5'd0);
    endtask

    task automatic test_reset_mid_read();
        bit seen = 1'b0;
        int vld = 0;
        rd_req = 1'b1; rd_addr = 5'd31;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = rd_gnt;
        end
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; last_m = 1;
        #1;
        checks++;
        if (!seen || rd_valid !== 1'b0 || rd_data !== '0 || RAM_W !== 1'b0) begin
            errors++;
            $display("FAIL midrd_reset: seen=%b rd_valid=%b rd_data=%h RAM_W=%b, want 1 0 0 0",
                     seen, rd_valid, rd_data, RAM_W);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rd_valid) vld++;
        end
        checks++;
        if (vld != 0 || rd_data !== '0) begin
            errors++;
            $display("FAIL midrd_aborted: rd_valid pulses=%0d rd_data=%h, want 0 0", vld, rd_data);
        end
        run_pair("midrd_next", 1'b0, 5'd0, 20'h0, 1'b1, 5'd31);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit w, r;
            w = 1'($urandom); r = 1'($urandom);
            if (!w && !r) w = 1'b1;
            run_pair($sformatf("rand%0d", i), w, AW'($urandom), DW'($urandom), r,
                     AW'(wq[$urandom_range(0, wq.size() - 1)]));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

`ifdef SEQ_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        checks++;
        if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: %0d %0d %0d, want 0 0 0", wr_cnt, rd_cnt, conflict_cnt);
        end
        run_pair("st_tie", 1'b1, 5'd9, 20'h0F0F0, 1'b1, 5'd7);
        run_pair("st_w2", 1'b1, 5'd10, 20'h11111, 1'b0, 5'd0);
        run_pair("st_w3", 1'b1, 5'd11, 20'h22222, 1'b0, 5'd0);
        run_pair("st_r2", 1'b0, 5'd0, 20'h0, 1'b1, 5'd10);
        checks++;
        if (wr_cnt !== 16'd3 || rd_cnt !== 16'd2 || conflict_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts: wr=%0d rd=%0d conflict=%0d, want 3 2 1",
                     wr_cnt, rd_cnt, conflict_cnt);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
`ifdef SEQ_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_ram_arbiter.md
Name: seq_ram_arbiter

Overview:
Owns the single port of the 32 x 20-bit sequence RAM and shares it between two requesters: the store path (writes captured sequences) and the playback/compare path (reads them back). A 2-way round-robin arbiter with a small FSM converts req/gnt handshakes into registered RAM_addr / RAM_W / RAM_din cycles and returns read data with a valid pulse. It sits between the sequence-store logic and the RAM macro.

Parameters:
ADDR_W, 5, RAM address width (32 entries)
DATA_W, 20, sequence word width (5 hex digits)
RD_LAT, 1, RAM read latency in cycles (1..3); synchronous-read RAM

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
wr_req  input  1  store path requests a write; held until wr_gnt
wr_addr  input  ADDR_W  write address, stable while wr_req high
wr_data  input  DATA_W  write data, stable while wr_req high
wr_gnt  output  1  one-cycle pulse: write is being performed this cycle
rd_req  input  1  playback path requests a read; held until rd_gnt
rd_addr  input  ADDR_W  read address, stable while rd_req high
rd_gnt  output  1  one-cycle pulse: read address accepted
rd_valid  output  1  one-cycle pulse: rd_data holds the new read result
rd_data  output  DATA_W  last read result, held until next rd_valid
RAM_addr  output  ADDR_W  registered RAM address
RAM_W  output  1  registered RAM write enable
RAM_din  output  DATA_W  registered RAM write data
RAM_dout  input  DATA_W  RAM read data

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; last-grant pointer = READ so the writer wins the first tie. Reset mid-transfer aborts it; RAM_W falls immediately; no rd_valid is emitted for an aborted read.
- States: IDLE, WRITE, READ, READ_WAIT.
- IDLE: requests are sampled only here. Only wr_req -> WRITE; only rd_req -> READ; both -> the requester not granted last; neither -> stay IDLE.
- On the edge leaving IDLE, RAM_addr/RAM_din are loaded from the winner's addr/data; RAM_W=1 only for WRITE.
- WRITE (1 cycle): RAM_W=1, wr_gnt=1; pointer := WRITE; -> IDLE with RAM_W=0.
- READ (1 cycle): RAM_W=0, rd_gnt=1; pointer := READ; -> READ_WAIT.
- READ_WAIT: down-counter loaded with RD_LAT-1; at 0, rd_data <= RAM_dout on that edge; rd_valid=1 during the following cycle (IDLE); -> IDLE.
- Latency: write = 2 cycles from req sampled to RAM write edge; read = RD_LAT+2 cycles from req sampled to rd_valid. Max throughput = one write per 2 cycles.
- Requesters drop req on the edge after seeing gnt; req withdrawn before being sampled in IDLE is ignored (no access).
- Read-after-write to the same address returns the new data (strict serialisation, no bypass needed).
- Addresses wrap naturally in ADDR_W bits; no range check.
- RAM_addr holds its last value in IDLE; RAM_din holds last write data.

Optional Feature:
SEQ_ARB_STATS_EN: when defined, adds outputs wr_cnt[15:0], rd_cnt[15:0], and conflict_cnt[15:0] (IDLE cycles with both requests high). All are saturating at 16'hFFFF and cleared by rst. When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package seq_ram_pkg: ADDR_W/DATA_W constants, state enum (IDLE, WRITE, READ, READ_WAIT), grant-owner enum (OWN_WR, OWN_RD).
- Sub-module rr_arb2: combinational 2-way round-robin arbiter with the pointer register; inputs req[1:0], update strobe; output one-hot grant. The FSM, RAM registers, and stats stay in seq_ram_arbiter.

Test Plan:
- Reset: rst=0 for 2 cycles with wr_req=1 -> no wr_gnt, RAM_W=0, all outputs 0; release -> first write granted in the 2nd cycle.
- Write then read: write 20'h58EA3 @ addr 5'd3, then read addr 3 -> RAM_W exactly 1 cycle with RAM_addr=3; rd_valid RD_LAT+2 cycles after rd_req is sampled; rd_data=20'h58EA3.
- Simultaneous: wr_req (addr 7, 20'h74DBA) and rd_req (addr 3) both high from reset -> write first, then read; the next tie goes to the writer only after a read has been granted (alternation over 4 ties).
- Back-to-back writes to addr 31 then addr 0 -> RAM_W pulses separated by one IDLE cycle; both words read back correctly (wrap).
- Reset mid-read: assert rst during READ_WAIT -> rd_valid never pulses and rd_data=0; the next read completes normally.
- With SEQ_ARB_STATS_EN: 3 writes, 2 reads, 1 tie -> wr_cnt=3, rd_cnt=2, conflict_cnt=1.
